// File: rtl/pc_if.sv
// pc_if: request and status signals between the pipeline and the fetch-PC unit
interface pc_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 3
);
  logic            keep, exc_req, redirect_valid, id_jump, id_call, id_ret;
  logic [XLEN-1:0] redirect_pc, id_jump_pc, id_link_pc, pc, pc4;
  logic [2:0]      pc_src;
  logic            ret_pred_valid, ras_empty;
  logic [CNT_W-1:0] ras_count;
  modport master(
    output keep, exc_req, redirect_valid, redirect_pc, id_jump, id_jump_pc, id_call, id_link_pc, id_ret,
    input  pc, pc4, pc_src, ret_pred_valid, ras_empty, ras_count
  );
  modport slave(
    input  keep, exc_req, redirect_valid, redirect_pc, id_jump, id_jump_pc, id_call, id_link_pc, id_ret,
    output pc, pc4, pc_src, ret_pred_valid, ras_empty, ras_count
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch-PC generator with prioritised next-PC select and circular return-address stack
module pc_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h00400000,
  parameter logic [XLEN-1:0] EXC_VEC   = 32'h80000180,
  parameter int              RAS_DEPTH = 4,
  parameter int              CNT_W     = $clog2(RAS_DEPTH) + 1
) (
  input logic clk,
  input logic rst,
  pc_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [XLEN-1:0] pc_q, pc4, nxt, top;
  logic [PW-1:0]   ptr, top_idx, wr_idx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      src;
  logic            rpv, empty, flush, upd, ras_op, push, pop;
  always_comb begin
    pc4     = pc_q + XLEN'(4);
    empty   = cnt == '0;
    flush   = bus.exc_req | bus.redirect_valid;
    upd     = !bus.keep | flush;
    ras_op  = !bus.keep & !flush;
    push    = ras_op & bus.id_call;
    pop     = ras_op & bus.id_ret & !empty;
    top_idx = ptr - PW'(1);
    top     = ras[top_idx];
    src     = bus.exc_req ? 3'd4 : bus.redirect_valid ? 3'd3 :
              (bus.id_ret && !empty) ? 3'd2 : bus.id_jump ? 3'd1 : 3'd0;
    nxt     = src == 3'd4 ? EXC_VEC : src == 3'd3 ? bus.redirect_pc :
              src == 3'd2 ? top : src == 3'd1 ? bus.id_jump_pc : pc4;
    // a simultaneous call and return overwrites the top in place
    wr_idx  = pop ? top_idx : ptr;
  end
  assign bus.pc             = pc_q;
  assign bus.pc4            = pc4;
  assign bus.pc_src         = src;
  assign bus.ret_pred_valid = rpv;
  assign bus.ras_empty      = empty;
  assign bus.ras_count      = cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc_q <= RESET_VEC;
      ptr  <= '0;
      cnt  <= '0;
      rpv  <= 1'b0;
    end else begin
      if (upd) begin
        pc_q <= nxt;
        rpv  <= src == 3'd2;
      end
      if (bus.exc_req) begin
        ptr <= '0;
        cnt <= '0;
      end else if (push && !pop) begin
        ptr <= ptr + PW'(1);
        cnt <= cnt == CNT_W'(RAS_DEPTH) ? cnt : cnt + CNT_W'(1);
      end else if (pop && !push) begin
        ptr <= top_idx;
        cnt <= cnt - CNT_W'(1);
      end
    end
  always_ff @(posedge clk)
    if (push) ras[wr_idx] <= bus.id_link_pc;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench comparing pc_unit against a stack-based reference model
module tb_pc_unit;
  localparam logic [31:0] RV = 32'h00400000;
  localparam logic [31:0] EV = 32'h80000180;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] pc, pc4;
    logic [2:0]  src;
    logic [2:0]  cnt;
    logic        empty, rpv;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0;
  int checks = 0, errors = 0;
  exp_t q[$];
  logic [31:0] stk[$];
  logic [31:0] m_pc = RV;
  logic m_rpv = 1'b0;
  pc_if #(.XLEN(32), .CNT_W(3)) bus();
  pc_unit dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", bus.pc, e.pc);
      chk("pc4", bus.pc4, e.pc4);
      chk("pc_src", 32'(bus.pc_src), 32'(e.src));
      chk("ras_count", 32'(bus.ras_count), 32'(e.cnt));
      chk("ras_empty", 32'(bus.ras_empty), 32'(e.empty));
      chk("ret_pred_valid", 32'(bus.ret_pred_valid), 32'(e.rpv));
    end
  task automatic step(input logic r, input logic k, input logic e, input logic rv, input logic [31:0] rpc,
                      input logic j, input logic [31:0] jpc, input logic c, input logic [31:0] lpc, input logic rt);
    exp_t x;
    logic [2:0] src;
    logic [31:0] nxt;
    @(posedge clk);
    #1;
    rst = r;
    bus.keep = k; bus.exc_req = e; bus.redirect_valid = rv; bus.redirect_pc = rpc;
    bus.id_jump = j; bus.id_jump_pc = jpc; bus.id_call = c; bus.id_link_pc = lpc; bus.id_ret = rt;
    if (!r) begin
      m_pc = RV;
      m_rpv = 1'b0;
      stk.delete();
    end
    src = e ? 3'd4 : rv ? 3'd3 : (rt && stk.size() > 0) ? 3'd2 : j ? 3'd1 : 3'd0;
    nxt = src == 3'd4 ? EV : src == 3'd3 ? rpc : src == 3'd2 ? stk[$] : src == 3'd1 ? jpc : m_pc + 32'd4;
    x.pc = m_pc; x.pc4 = m_pc + 32'd4; x.src = src;
    x.cnt = 3'(stk.size()); x.empty = stk.size() == 0; x.rpv = m_rpv;
    q.push_back(x);
    if (r) begin
      if (!k || e || rv) begin
        m_pc = nxt;
        m_rpv = src == 3'd2;
      end
      if (e) stk.delete();
      else if (!k && !rv) begin
        if (c && rt && stk.size() > 0) begin
          void'(stk.pop_back());
          stk.push_back(lpc);
        end else if (c) begin
          stk.push_back(lpc);
          if (stk.size() > DEPTH) void'(stk.pop_front());
        end else if (rt && stk.size() > 0) void'(stk.pop_back());
      end
    end
  endtask
  task automatic idle(); step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic call(input logic [31:0] l); step(1, 0, 0, 0, 0, 0, 0, 1, l, 0); endtask
  task automatic ret(); step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic redir(input logic [31:0] t); step(1, 0, 0, 1, t, 0, 0, 0, 0, 0); endtask
  initial begin
    bus.keep = 0; bus.exc_req = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    bus.id_jump = 0; bus.id_jump_pc = 0; bus.id_call = 0; bus.id_link_pc = 0; bus.id_ret = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) idle();
    repeat (2) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 32'h00400100, 0, 0, 0, 0, 0);
    idle();
    step(1, 0, 0, 0, 0, 1, 32'h00400200, 1, 32'h00400010, 0);
    repeat (2) idle();
    ret();
    idle();
    for (int i = 0; i < 5; i++) call(32'h00500000 + 32'(i) * 32'h10);
    repeat (5) ret();
    idle();
    call(32'h00600000);
    call(32'h00600010);
    step(1, 0, 1, 1, 32'h00400400, 0, 0, 1, 32'h00600020, 1);
    idle();
    step(1, 1, 0, 0, 0, 0, 0, 1, 32'h00610000, 1);
    call(32'h00700000);
    call(32'h00700010);
    call(32'h00700020);
    redir(32'h00400300);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    call(32'h00800000);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h00800010, 1);
    ret();
    redir(32'hFFFFFFFC);
    repeat (2) idle();
    for (int i = 0; i < 400; i++)
      step(1, $urandom % 4 == 0, $urandom % 32 == 0, $urandom % 16 == 0, {$urandom, 2'b00},
           $urandom % 5 == 0, {$urandom, 2'b00}, $urandom % 3 == 0, {$urandom, 2'b00}, $urandom % 3 == 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
